unigate_lane_array: RTL and testbench



---
 rtl/unigate_lane_array_pkg.sv | 40 ++++
 rtl/unigate_lane_array_lane.sv | 54 +++++
 rtl/unigate_lane_array.sv | 64 ++++++
 tb/tb_unigate_lane_array.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/unigate_lane_array_pkg.sv
// Shared types, named function codes and the u21 wiring decoder for the unigate lane array.
package unigate_lane_array_pkg;

   typedef logic [3:0] func_code_t;

   localparam func_code_t FN_ZERO = 4'b0000;
   localparam func_code_t FN_AND  = 4'b0001;
   localparam func_code_t FN_XOR  = 4'b0110;
   localparam func_code_t FN_OR   = 4'b0111;
   localparam func_code_t FN_NOR  = 4'b1000;
   localparam func_code_t FN_XNOR = 4'b1001;
   localparam func_code_t FN_NAND = 4'b1110;
   localparam func_code_t FN_ONE  = 4'b1111;

   // Maps a truth-table code onto the {in3,in2,in1,in0} wiring of u21 so that
   // (in3 & ~in2) ^ in1 ^ in0 reproduces the requested function of a and b.
   function automatic logic [3:0] wire_decode(input func_code_t code, input logic a, input logic b);
      logic [3:0] w;
      case (code)
         4'h0:    w = 4'b0000;
         4'h1:    w = {a, b, a, 1'b0};
         4'h2:    w = {b, a, 2'b00};
         4'h3:    w = {b, 3'b000};
         4'h4:    w = {a, b, 2'b00};
         4'h5:    w = {a, 3'b000};
         4'h6:    w = {b, 1'b0, a, 1'b0};
         4'h7:    w = {b, a, a, 1'b0};
         4'h8:    w = {b, a, a, 1'b1};
         4'h9:    w = {1'b1, b, a, 1'b0};
         4'hA:    w = {1'b1, a, 2'b00};
         4'hB:    w = {a, b, 1'b1, 1'b0};
         4'hC:    w = {1'b1, b, 2'b00};
         4'hD:    w = {b, a, 1'b1, 1'b0};
         4'hE:    w = {a, b, a, 1'b1};
         default: w = 4'b1000;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/unigate_lane_array_lane.sv
// Leaf primitives u21 and mux2, and one universal-gate lane built from them.
// UNIGATE_SELFCHECK_EN adds a mux2 golden reference and drives the lane error flag.
module u21 (
   input  logic [3:0] in,
   output logic       out
);
   assign out = (in[3] & ~in[2]) ^ in[1] ^ in[0];
endmodule

module mux2 (
   input  logic [1:0] sel,
   input  logic [3:0] in,
   output logic       out
);
   assign out = in[{~sel[0], ~sel[1]}];
endmodule

module unigate_lane
   import unigate_lane_array_pkg::*;
(
   input  func_code_t func,
   input  logic       a,
   input  logic       b,
   output logic       y,
   output logic       err
);

   logic [3:0] gate_in;
   logic       gate_out;

   assign gate_in = wire_decode(func, a, b);

   u21 u_gate (
      .in  (gate_in),
      .out (gate_out)
   );

   assign y = gate_out;

`ifdef UNIGATE_SELFCHECK_EN
   logic ref_out;

   mux2 u_ref (
      .sel ({a, b}),
      .in  (func),
      .out (ref_out)
   );

   assign err = gate_out ^ ref_out;
`else
   assign err = 1'b0;
`endif

endmodule

// File: rtl/unigate_lane_array.sv
// Registered bank of WIDTH programmable 2-input gate lanes sharing one function register.
// UNIGATE_SELFCHECK_EN enables the sticky mismatch flag fed by per-lane mux2 references.
module unigate_lane_array
   import unigate_lane_array_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [3:0]       cfg_func,
   output logic [3:0]       func_q,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             out_valid,
   output logic             mismatch
);

   logic [WIDTH-1:0] lane_y;
   logic [WIDTH-1:0] lane_err;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : gen_lane
         unigate_lane u_lane (
            .func (func_q),
            .a    (a[i]),
            .b    (b[i]),
            .y    (lane_y[i]),
            .err  (lane_err[i])
         );
      end
   endgenerate

   // Lanes read the registered function, so a write and a data beat in the
   // same cycle naturally evaluate the data with the previous function.
   always_ff @(posedge clk) begin
      if (rst) begin
         func_q    <= FN_ZERO;
         y         <= '0;
         out_valid <= 1'b0;
      end else begin
         if (cfg_we)
            func_q <= cfg_func;
         if (in_valid)
            y <= lane_y;
         out_valid <= in_valid;
      end
   end

`ifdef UNIGATE_SELFCHECK_EN
   always_ff @(posedge clk) begin
      if (rst)
         mismatch <= 1'b0;
      else if (in_valid && (|lane_err))
         mismatch <= 1'b1;
   end
`else
   assign mismatch = |lane_err;
`endif

endmodule

// File: tb/tb_unigate_lane_array.sv
// Table-driven scoreboard bench for unigate_lane_array; the mismatch sequence runs only with UNIGATE_SELFCHECK_EN.
module tb_unigate_lane_array;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_we;
   logic [3:0]       cfg_func;
   logic [3:0]       func_q;
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] y;
   logic             out_valid;
   logic             mismatch;

   int               n_checks = 0;
   int               n_fail   = 0;
   logic [7:0]       exp_q[$];
   logic [3:0]       model_func;

   typedef struct {
      logic       we;
      logic [3:0] fc;
      logic       v;
      logic [7:0] av;
      logic [7:0] bv;
      logic [7:0] ey;
   } vec_t;

   vec_t tbl[8];

   unigate_lane_array #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_func  (cfg_func),
      .func_q    (func_q),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .y         (y),
      .out_valid (out_valid),
      .mismatch  (mismatch)
   );

   always #5 clk = ~clk;

   // Truth-table reference: lane result is func indexed by {~b,~a}.
   function automatic logic [7:0] model_y(input logic [3:0] f, input logic [7:0] av, input logic [7:0] bv);
      logic [7:0] r;
      logic [1:0] idx;
      for (int i = 0; i < 8; i++) begin
         idx  = {~bv[i], ~av[i]};
         r[i] = f[idx];
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic we, input logic [3:0] fc, input logic v,
                                input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ey);
      cfg_we   = we;
      cfg_func = fc;
      in_valid = v;
      a        = av;
      b        = bv;
      if (v)
         exp_q.push_back(ey);
      if (we)
         model_func = fc;
      @(posedge clk);
      #1;
      cfg_we   = 1'b0;
      in_valid = 1'b0;
   endtask

   // Scoreboard drain: every out_valid beat must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_out_valid: got y=%h, want no output", y);
         end else begin
            checkOutput("y", {24'b0, y}, {24'b0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      logic [7:0] av;
      logic [7:0] bv;

      rst        = 1'b1;
      cfg_we     = 1'b0;
      cfg_func   = 4'b0;
      in_valid   = 1'b0;
      a          = '0;
      b          = '0;
      model_func = 4'b0;

      tbl[0] = '{we:1'b0, fc:4'b0000, v:1'b1, av:8'hFF, bv:8'hFF, ey:8'h00};
      tbl[1] = '{we:1'b1, fc:4'b0110, v:1'b0, av:8'h00, bv:8'h00, ey:8'h00};
      tbl[2] = '{we:1'b0, fc:4'b0000, v:1'b1, av:8'h0F, bv:8'h33, ey:8'h3C};
      tbl[3] = '{we:1'b1, fc:4'b0001, v:1'b0, av:8'h00, bv:8'h00, ey:8'h00};
      tbl[4] = '{we:1'b0, fc:4'b0000, v:1'b1, av:8'h0F, bv:8'h33, ey:8'h03};
      tbl[5] = '{we:1'b1, fc:4'b0111, v:1'b0, av:8'h00, bv:8'h00, ey:8'h00};
      tbl[6] = '{we:1'b1, fc:4'b1000, v:1'b1, av:8'hFF, bv:8'h00, ey:8'hFF};
      tbl[7] = '{we:1'b0, fc:4'b0000, v:1'b1, av:8'h00, bv:8'h00, ey:8'hFF};

      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("reset_func_q", {28'b0, func_q}, 32'h0);
      checkOutput("reset_y", {24'b0, y}, 32'h0);
      checkOutput("reset_out_valid", {31'b0, out_valid}, 32'h0);
      checkOutput("reset_mismatch", {31'b0, mismatch}, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++)
         applyStimulus(tbl[i].we, tbl[i].fc, tbl[i].v, tbl[i].av, tbl[i].bv, tbl[i].ey);
      checkOutput("pulse_out_valid_high", {31'b0, out_valid}, 32'h1);
      checkOutput("func_q_after_cfg", {28'b0, func_q}, 32'h8);

      applyStimulus(1'b0, 4'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      checkOutput("idle_out_valid_low", {31'b0, out_valid}, 32'h0);
      checkOutput("idle_y_hold", {24'b0, y}, 32'hFF);

      for (int c = 0; c < 16; c++) begin
         applyStimulus(1'b1, 4'(c), 1'b0, 8'h00, 8'h00, 8'h00);
         for (int k = 0; k < 4; k++) begin
            av = {8{k[0]}};
            bv = {8{k[1]}};
            applyStimulus(1'b0, 4'b0, 1'b1, av, bv, model_y(model_func, av, bv));
         end
         applyStimulus(1'b0, 4'b0, 1'b1, 8'h55, 8'h33, model_y(model_func, 8'h55, 8'h33));
      end
      checkOutput("sweep_mismatch_clear", {31'b0, mismatch}, 32'h0);

      applyStimulus(1'b1, 4'b1011, 1'b0, 8'h00, 8'h00, 8'h00);
      applyStimulus(1'b0, 4'b0, 1'b1, 8'hFF, 8'h00, 8'h00);

      applyStimulus(1'b0, 4'b0, 1'b1, 8'hAA, 8'h55, model_y(model_func, 8'hAA, 8'h55));
      rst      = 1'b1;
      in_valid = 1'b1;
      a        = 8'hFF;
      b        = 8'h00;
      @(posedge clk); #1;
      rst        = 1'b0;
      in_valid   = 1'b0;
      model_func = 4'b0;
      exp_q.delete();
      checkOutput("midreset_y", {24'b0, y}, 32'h0);
      checkOutput("midreset_out_valid", {31'b0, out_valid}, 32'h0);
      checkOutput("midreset_func_q", {28'b0, func_q}, 32'h0);

      applyStimulus(1'b0, 4'b0, 1'b1, 8'hFF, 8'hFF, 8'h00);
      applyStimulus(1'b0, 4'b0, 1'b0, 8'h00, 8'h00, 8'h00);

`ifdef UNIGATE_SELFCHECK_EN
      applyStimulus(1'b1, 4'b1111, 1'b0, 8'h00, 8'h00, 8'h00);
      force dut.gen_lane[0].u_lane.gate_out = 1'b0;
      applyStimulus(1'b0, 4'b0, 1'b1, 8'h0F, 8'h33, 8'hFE);
      release dut.gen_lane[0].u_lane.gate_out;
      checkOutput("selfcheck_mismatch_set", {31'b0, mismatch}, 32'h1);
      applyStimulus(1'b0, 4'b0, 1'b1, 8'h0F, 8'h33, 8'hFF);
      checkOutput("selfcheck_mismatch_sticky", {31'b0, mismatch}, 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst        = 1'b0;
      model_func = 4'b0;
      exp_q.delete();
      checkOutput("selfcheck_mismatch_cleared", {31'b0, mismatch}, 32'h0);
`endif

      @(negedge clk);
      checkOutput("scoreboard_drained", exp_q.size(), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
